// File: rtl/complex_divider.sv
// complex_divider: sequential fixed-point complex division (a_r + j a_i) / (b_r + j b_i).
// Numerators are formed by conjugate multiply; both parts share one restoring shift-subtract pass.
module complex_divider #(
    parameter int fractional_size = 12,
    parameter int operand_size    = 16,
    parameter int expansion_size  = operand_size
) (
    input  logic                                          i_clk,
    input  logic                                          i_rst_n,
    input  logic                                          i_valid,
    output logic                                          o_ready,
    input  logic signed [operand_size-1:0]                i_a_real,
    input  logic signed [operand_size-1:0]                i_a_imag,
    input  logic signed [operand_size-1:0]                i_b_real,
    input  logic signed [operand_size-1:0]                i_b_imag,
    output logic signed [operand_size+expansion_size-1:0] o_res_real,
    output logic signed [operand_size+expansion_size-1:0] o_res_imag,
    output logic                                          o_valid,
    output logic                                          o_div_zero
);
    localparam int res_w = operand_size + expansion_size;
    localparam int p_w   = 2 * operand_size;
    localparam int n_w   = p_w + 1;
    localparam int div_w = n_w + fractional_size + res_w;
    localparam int cnt_w = $clog2(res_w);
    localparam logic [res_w-1:0] sat = {1'b0, {(res_w-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, PREP, DIV, FIX} state_t;

    state_t                    r_state;
    logic signed [operand_size-1:0] r_a_r, r_a_i, r_b_r, r_b_i;
    logic [p_w-1:0]            r_d;
    logic                      r_zero;
    logic [cnt_w-1:0]          r_cnt;
    logic [p_w-1:0]            r_rem [2];
    logic [res_w-1:0]          r_q [2];
    logic                      r_neg [2];
    logic                      r_ovf [2];

    logic signed [p_w-1:0]     w_p [6];
    logic signed [n_w-1:0]     w_n [2];
    logic [p_w-1:0]            w_d;
    logic [n_w-1:0]            w_abs [2];
    logic [div_w-1:0]          w_dvd [2];
    logic                      w_ovf [2];
    logic [n_w-1:0]            w_t [2];
    logic                      w_ge [2];
    logic [n_w-1:0]            w_nx [2];
    logic [res_w-1:0]          w_mag [2];
    logic [res_w-1:0]          w_res [2];

    assign w_p[0] = p_w'(r_a_r) * p_w'(r_b_r);
    assign w_p[1] = p_w'(r_a_i) * p_w'(r_b_i);
    assign w_p[2] = p_w'(r_a_i) * p_w'(r_b_r);
    assign w_p[3] = p_w'(r_a_r) * p_w'(r_b_i);
    assign w_p[4] = p_w'(r_b_r) * p_w'(r_b_r);
    assign w_p[5] = p_w'(r_b_i) * p_w'(r_b_i);
    assign w_n[0] = n_w'(w_p[0]) + n_w'(w_p[1]);
    assign w_n[1] = n_w'(w_p[2]) - n_w'(w_p[3]);
    assign w_d    = w_p[4] + w_p[5];

    // The partial remainder always stays below D, so it fits in p_w bits.
    for (genvar g = 0; g < 2; g++) begin : g_part
        assign w_abs[g] = w_n[g][n_w-1] ? -w_n[g] : w_n[g];
        assign w_dvd[g] = div_w'(w_abs[g]) << fractional_size;
        assign w_ovf[g] = w_dvd[g] >= (div_w'(w_d) << (res_w - 1));
        assign w_t[g]   = {r_rem[g], r_q[g][res_w-1]};
        assign w_ge[g]  = w_t[g] >= n_w'(r_d);
        assign w_nx[g]  = w_ge[g] ? w_t[g] - n_w'(r_d) : w_t[g];
        assign w_mag[g] = r_ovf[g] ? sat : r_q[g];
        assign w_res[g] = r_zero ? '0 : r_neg[g] ? -w_mag[g] : w_mag[g];
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            o_ready    <= 1'b1;
            o_valid    <= 1'b0;
            o_div_zero <= 1'b0;
            o_res_real <= '0;
            o_res_imag <= '0;
            r_a_r      <= '0;
            r_a_i      <= '0;
            r_b_r      <= '0;
            r_b_i      <= '0;
            r_d        <= '0;
            r_zero     <= 1'b0;
            r_cnt      <= '0;
            for (int i = 0; i < 2; i++) begin
                r_rem[i] <= '0;
                r_q[i]   <= '0;
                r_neg[i] <= 1'b0;
                r_ovf[i] <= 1'b0;
            end
        end else begin
            o_valid <= 1'b0;
            case (r_state)
                IDLE: if (i_valid) begin
                    r_a_r   <= i_a_real;
                    r_a_i   <= i_a_imag;
                    r_b_r   <= i_b_real;
                    r_b_i   <= i_b_imag;
                    o_ready <= 1'b0;
                    r_state <= PREP;
                end
                PREP: begin
                    r_d     <= w_d;
                    r_zero  <= w_d == '0;
                    r_cnt   <= '0;
                    for (int i = 0; i < 2; i++) begin
                        r_rem[i] <= p_w'(w_dvd[i] >> res_w);
                        r_q[i]   <= w_dvd[i][res_w-1:0];
                        r_neg[i] <= w_n[i][n_w-1];
                        r_ovf[i] <= w_ovf[i];
                    end
                    r_state <= DIV;
                end
                DIV: begin
                    for (int i = 0; i < 2; i++) begin
                        r_rem[i] <= p_w'(w_nx[i]);
                        r_q[i]   <= {r_q[i][res_w-2:0], w_ge[i]};
                    end
                    r_cnt   <= r_cnt + 1'b1;
                    r_state <= r_cnt == cnt_w'(res_w - 1) ? FIX : DIV;
                end
                FIX: begin
                    o_res_real <= w_res[0];
                    o_res_imag <= w_res[1];
                    o_div_zero <= r_zero;
                    o_valid    <= 1'b1;
                    o_ready    <= 1'b1;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_complex_divider.sv
// tb_complex_divider: directed and random checks of complex_divider against an arithmetic model.
module tb_complex_divider;
    localparam int F  = 12;
    localparam int W  = 32;
    localparam int W2 = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic vin = 1'b0;
    logic v24 = 1'b0;
    logic signed [15:0] ar = '0, ai = '0, br = '0, bi = '0;
    logic rdy, vld, dz, rdy24, vld24, dz24;
    logic signed [W-1:0]  rr, ri;
    logic signed [W2-1:0] rr24, ri24;

    always #5 clk = ~clk;

    complex_divider dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(vin), .o_ready(rdy),
        .i_a_real(ar), .i_a_imag(ai), .i_b_real(br), .i_b_imag(bi),
        .o_res_real(rr), .o_res_imag(ri), .o_valid(vld), .o_div_zero(dz)
    );

    complex_divider #(.expansion_size(8)) dut24 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v24), .o_ready(rdy24),
        .i_a_real(ar), .i_a_imag(ai), .i_b_real(br), .i_b_imag(bi),
        .o_res_real(rr24), .o_res_imag(ri24), .o_valid(vld24), .o_div_zero(dz24)
    );

    int ncmp = 0;
    int nfail = 0;
    int cnt_m = 0;
    int npulse = 0;
    bit pulse_m = 0;
    longint held_r = 0, held_i = 0, nxt_r = 0, nxt_i = 0;
    bit held_dz = 0, nxt_dz = 0;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint part(input longint n, input longint d, input int w);
        longint q = ((n < 0 ? -n : n) * (longint'(1) << F)) / d;
        longint s = (longint'(1) << (w - 1)) - 1;
        if (q > s) q = s;
        return n < 0 ? -q : q;
    endfunction

    task automatic ref_div(input int w, input longint a_r, a_i, b_r, b_i,
                           output longint r_r, r_i, output bit z);
        longint nr = a_r * b_r + a_i * b_i;
        longint ni = a_i * b_r - a_r * b_i;
        longint d  = b_r * b_r + b_i * b_i;
        z   = d == 0;
        r_r = z ? 0 : part(nr, d, w);
        r_i = z ? 0 : part(ni, d, w);
    endtask

    // One clock of the reference: idle accepts, busy counts down W+2 edges to the result.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            if (cnt_m == 0) begin
                pulse_m = 0;
                if (vin) begin
                    ref_div(W, ar, ai, br, bi, nxt_r, nxt_i, nxt_dz);
                    cnt_m = W + 2;
                end
            end else begin
                cnt_m--;
                pulse_m = cnt_m == 0;
                if (pulse_m) begin
                    held_r = nxt_r;
                    held_i = nxt_i;
                    held_dz = nxt_dz;
                end
            end
        end
        #1;
        if (vld === 1'b1) npulse++;
        check("ready", rdy, cnt_m == 0);
        check("valid", vld, pulse_m);
        check("res_real", rr, held_r);
        check("res_imag", ri, held_i);
        check("div_zero", dz, held_dz);
    endtask

    task automatic rand_ops();
        ar = 16'($urandom);
        ai = 16'($urandom);
        br = 16'($urandom);
        bi = 16'($urandom);
    endtask

    task automatic issue(input longint a_r, a_i, b_r, b_i);
        ar = 16'(a_r);
        ai = 16'(a_i);
        br = 16'(b_r);
        bi = 16'(b_i);
        vin = 1'b1;
        cycle();
        vin = 1'b0;
        repeat (W + 3) begin
            rand_ops();
            cycle();
        end
    endtask

    initial begin
        longint er, ei;
        bit ez;
        int n;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", rdy, 1);
        check("rst_valid", vld, 0);
        check("rst_dz", dz, 0);
        check("rst_real", rr, 0);
        check("rst_imag", ri, 0);
        check("rst_ready24", rdy24, 1);
        rst_n = 1'b1;
        repeat (2) cycle();

        issue(8192, 12288, 4096, 4096);
        check("tc1_real", rr, 10240);
        check("tc1_imag", ri, 2048);
        check("tc1_dz", dz, 0);
        issue(4096, 0, 0, 4096);
        check("inv_j_real", rr, 0);
        check("inv_j_imag", ri, -4096);
        issue(-4096, -4096, 4096, 0);
        check("neg_real", rr, -4096);
        check("neg_imag", ri, -4096);
        issue(4096, 4096, 0, 0);
        check("zero_real", rr, 0);
        check("zero_imag", ri, 0);
        check("zero_dz", dz, 1);

        repeat (24) begin
            rand_ops();
            if ($urandom_range(0, 7) == 0) begin
                br = '0;
                bi = '0;
            end else if ($urandom_range(0, 3) == 0) begin
                br = 16'($urandom_range(0, 15)) - 16'sd8;
                bi = 16'($urandom_range(0, 3)) - 16'sd2;
            end
            issue(ar, ai, br, bi);
        end
        issue(-32768, -32768, -32768, -32768);
        issue(32767, -32768, 1, 0);

        npulse = 0;
        vin = 1'b1;
        for (int c = 0; c < 3 * (W + 3); c++) begin
            rand_ops();
            cycle();
        end
        vin = 1'b0;
        repeat (W + 8) cycle();
        check("b2b_results", npulse, 3);

        ar = 16'sd8192;
        ai = 16'sd4096;
        br = 16'sd4096;
        bi = -16'sd4096;
        vin = 1'b1;
        cycle();
        vin = 1'b0;
        repeat (10) cycle();
        #2;
        rst_n = 1'b0;
        cnt_m = 0;
        pulse_m = 0;
        held_r = 0;
        held_i = 0;
        held_dz = 0;
        #1;
        check("abort_ready", rdy, 1);
        check("abort_valid", vld, 0);
        check("abort_real", rr, 0);
        check("abort_imag", ri, 0);
        check("abort_dz", dz, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        npulse = 0;
        repeat (W + 8) cycle();
        check("abort_no_valid", npulse, 0);
        issue(-8192, 4096, 0, -4096);
        check("post_real", rr, -4096);
        check("post_imag", ri, -8192);

        ar = 16'sd32767;
        ai = -16'sd32768;
        br = 16'sd1;
        bi = 16'sd0;
        ref_div(W2, ar, ai, br, bi, er, ei, ez);
        v24 = 1'b1;
        @(posedge clk);
        #1;
        v24 = 1'b0;
        rand_ops();
        n = 0;
        while (vld24 !== 1'b1 && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("sat_latency", n, W2 + 2);
        check("sat_real", rr24, 8388607);
        check("sat_imag", ri24, -8388607);
        check("sat_model_real", rr24, er);
        check("sat_model_imag", ri24, ei);
        check("sat_dz", dz24, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
